// File: rtl/cksum_writeback_pkg.sv
// cksum_writeback_pkg: shared bus widths and byte-lane mask helper
package cksum_writeback_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  function automatic logic [DATA_W-1:0] lane_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction
endpackage

// File: rtl/cksum_writeback_lane_map.sv
// cksum_lane_map: big-endian lane/sel/data mapping of a 16-bit checksum into 32-bit words
module cksum_lane_map
  import cksum_writeback_pkg::*;
(
  input  logic [1:0]        lane_i,
  input  logic [15:0]       val_i,
  output logic [DATA_W-1:0] data_a_o,
  output logic [DATA_W-1:0] data_b_o,
  output logic [3:0]        sel_a_o,
  output logic [3:0]        sel_b_o,
  output logic              straddle_o
);
  always_comb begin
    data_a_o   = {val_i, 16'h0} >> {lane_i, 3'b000};
    sel_a_o    = 4'b1100 >> lane_i;
    data_b_o   = {val_i[7:0], 24'h0};
    sel_b_o    = 4'b1000;
    straddle_o = &lane_i;
  end
endmodule

// File: rtl/cksum_writeback.sv
// cksum_writeback: writes a 16-bit checksum big-endian into SRAM and verifies it by readback
module cksum_writeback
  import cksum_writeback_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [15:0]       cksum_val_i,
  input  logic [ADDR_W-1:0] field_addr_i,
  output logic              sram_ce_o,
  output logic              sram_we_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [3:0]        sram_sel_o,
  output logic [DATA_W-1:0] sram_data_o,
  input  logic [DATA_W-1:0] sram_data_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] WR_A = 3'd1;
  localparam logic [2:0] WR_B = 3'd2;
  localparam logic [2:0] RD_A = 3'd3;
  localparam logic [2:0] RD_B = 3'd4;
  localparam logic [2:0] CHK  = 3'd5;
  localparam logic [2:0] DONE = 3'd6;
  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       val_q, val_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] data_a, data_b;
  logic [3:0]        sel_a, sel_b;
  logic              straddle, accept, part_b, chk_b, mismatch;
  logic [ADDR_W-3:0] word_a, word_b;
  cksum_lane_map u_lane_map (
    .lane_i     (addr_q[1:0]),
    .val_i      (val_q),
    .data_a_o   (data_a),
    .data_b_o   (data_b),
    .sel_a_o    (sel_a),
    .sel_b_o    (sel_b),
    .straddle_o (straddle)
  );
  always_comb begin
    word_a      = addr_q[ADDR_W-1:2];
    word_b      = word_a + 1'b1;
    accept      = state_q == IDLE && start_i;
    part_b      = state_q == WR_B || state_q == RD_B;
    sram_ce_o   = state_q inside {WR_A, WR_B, RD_A, RD_B};
    sram_we_o   = state_q == WR_A || state_q == WR_B;
    sram_addr_o = !sram_ce_o ? '0 : {2'b00, part_b ? word_b : word_a};
    sram_sel_o  = !sram_ce_o ? '0 : part_b ? sel_b : sel_a;
    sram_data_o = !sram_we_o ? '0 : part_b ? data_b : data_a;
    chk_b       = state_q == CHK && straddle;
    mismatch    = (state_q == RD_B || state_q == CHK) &&
                  |((sram_data_i ^ (chk_b ? data_b : data_a)) & lane_mask(chk_b ? sel_b : sel_a));
    state_d     = state_q == IDLE ? (start_i ? WR_A : IDLE) :
                  state_q == WR_A ? (straddle ? WR_B : RD_A) :
                  state_q == WR_B ? RD_A :
                  state_q == RD_A ? (straddle ? RD_B : CHK) :
                  state_q == RD_B ? CHK :
                  state_q == CHK  ? DONE : IDLE;
    addr_d      = accept ? field_addr_i : addr_q;
    val_d       = accept ? cksum_val_i : val_q;
    err_d       = accept ? 1'b0 : err_q | mismatch;
    busy_o      = state_q != IDLE;
    done_o      = state_q == DONE;
    err_o       = done_o && err_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      val_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      val_q   <= val_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_cksum_writeback.sv
// tb_cksum_writeback: vector, corner-case and randomized checks of cksum_writeback against a byte-level memory model
module tb_cksum_writeback;
  logic        clk = 1'b0;
  logic        rst, start_i;
  logic [15:0] cksum_val_i, field_addr_i;
  logic        sram_ce_o, sram_we_o, busy_o, done_o, err_o;
  logic [15:0] sram_addr_o;
  logic [3:0]  sram_sel_o;
  logic [31:0] sram_data_o, sram_data_i, rdata;
  logic [31:0] mem [0:16383];
  logic        poke_en, force_top;
  logic [13:0] poke_a;
  logic [31:0] poke_d;
  int          n_cmp = 0, n_fail = 0;
  always #5 clk = ~clk;
  cksum_writeback dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .cksum_val_i  (cksum_val_i),
    .field_addr_i (field_addr_i),
    .sram_ce_o    (sram_ce_o),
    .sram_we_o    (sram_we_o),
    .sram_addr_o  (sram_addr_o),
    .sram_sel_o   (sram_sel_o),
    .sram_data_o  (sram_data_o),
    .sram_data_i  (sram_data_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );
  assign sram_data_i = force_top ? {8'h00, rdata[23:0]} : rdata;
  always @(posedge clk) begin
    if (poke_en) mem[poke_a] <= poke_d;
    else if (sram_ce_o && sram_we_o)
      for (int i = 0; i < 4; i++)
        if (sram_sel_o[i]) mem[sram_addr_o[13:0]][8*i +: 8] <= sram_data_o[8*i +: 8];
    if (sram_ce_o && !sram_we_o) rdata <= mem[sram_addr_o[13:0]];
  end
  typedef struct {
    logic [15:0] addr;
    logic [15:0] val;
    logic [31:0] init_a, init_b, exp_a, exp_b;
    logic [3:0]  sel;
    int          lat;
  } vec_t;
  vec_t vecs [5];
  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask
  task automatic poke(input logic [13:0] a, input logic [31:0] d);
    @(negedge clk);
    poke_en = 1'b1; poke_a = a; poke_d = d;
    @(posedge clk); #1 poke_en = 1'b0;
  endtask
  task automatic check_idle(input string tag);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_err"}, err_o, 0);
    check({tag, "_ce"}, sram_ce_o, 0);
    check({tag, "_we"}, sram_we_o, 0);
    check({tag, "_addr"}, sram_addr_o, 0);
    check({tag, "_sel"}, sram_sel_o, 0);
    check({tag, "_data"}, sram_data_o, 0);
  endtask
  task automatic run_op(input logic [15:0] a, input logic [15:0] v, output int lat, output logic e, output logic [3:0] s);
    int n = 0;
    @(negedge clk);
    field_addr_i = a; cksum_val_i = v; start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    s = sram_sel_o;
    while (!done_o && n < 20) begin
      @(posedge clk); #1 n++;
    end
    lat = n + 1;
    e = err_o;
    @(posedge clk); #1;
    check("done_single_pulse", done_o, 0);
    check("idle_after_done", busy_o, 0);
  endtask
  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] lane, input logic [7:0] b);
    w[31 - 8*lane -: 8] = b;
    return w;
  endfunction
  initial begin
    int          lat, dones;
    logic        e;
    logic [3:0]  s;
    logic [15:0] a, a1, v;
    logic [13:0] wa, wb;
    logic [31:0] ea, eb;
    vecs[0] = '{16'd24,     16'hB1E6, 32'h0000_1234, 32'h0000_1234, 32'hB1E6_1234, 32'hB1E6_1234, 4'b1100, 4};
    vecs[1] = '{16'd50,     16'hA5C3, 32'hDEAD_0000, 32'hDEAD_0000, 32'hDEAD_A5C3, 32'hDEAD_A5C3, 4'b0011, 4};
    vecs[2] = '{16'd27,     16'h1357, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FF13, 32'h57FF_FFFF, 4'b0001, 6};
    vecs[3] = '{16'd9,      16'hBEEF, 32'h1122_3344, 32'h1122_3344, 32'h11BE_EF44, 32'h11BE_EF44, 4'b0110, 4};
    vecs[4] = '{16'hFFFF,   16'hC0DE, 32'hAAAA_AAAA, 32'h5555_5555, 32'hAAAA_AAC0, 32'hDE55_5555, 4'b0001, 6};
    rst = 1'b1; start_i = 1'b0; cksum_val_i = '0; field_addr_i = '0;
    poke_en = 1'b0; poke_a = '0; poke_d = '0; force_top = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_idle("reset");
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a1 = vecs[i].addr + 16'd1;
      poke(vecs[i].addr[15:2], vecs[i].init_a);
      if (a1[15:2] != vecs[i].addr[15:2]) poke(a1[15:2], vecs[i].init_b);
      run_op(vecs[i].addr, vecs[i].val, lat, e, s);
      check($sformatf("vec%0d_word_a", i), mem[vecs[i].addr[15:2]], vecs[i].exp_a);
      check($sformatf("vec%0d_word_b", i), mem[a1[15:2]], vecs[i].exp_b);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_err", i), e, 0);
      check($sformatf("vec%0d_first_sel", i), s, vecs[i].sel);
    end
    poke(14'd6, 32'h0000_1234);
    force_top = 1'b1;
    run_op(16'd24, 16'hB1E6, lat, e, s);
    force_top = 1'b0;
    check("forced_readback_err", e, 1);
    check("forced_readback_latency", lat, 4);
    poke(14'd6, 32'h0000_1234);
    poke(14'd12, 32'hDEAD_0000);
    @(negedge clk);
    field_addr_i = 16'd24; cksum_val_i = 16'hB1E6; start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    @(posedge clk); #1;
    start_i = 1'b1; field_addr_i = 16'd50; cksum_val_i = 16'hFFFF;
    @(posedge clk); #1 start_i = 1'b0;
    dones = 0; e = 1'b0;
    repeat (10) begin
      if (done_o) begin dones++; e = err_o; end
      @(posedge clk); #1;
    end
    check("busy_start_done_count", dones, 1);
    check("busy_start_err", e, 0);
    check("busy_start_word6", mem[6], 32'hB1E6_1234);
    check("busy_start_word12", mem[12], 32'hDEAD_0000);
    poke(14'd6, 32'h0);
    poke(14'd7, 32'h0);
    @(negedge clk);
    field_addr_i = 16'd27; cksum_val_i = 16'h1357; start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    check("abort_in_write", sram_we_o, 1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check_idle("abort");
    dones = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done_o) dones++;
    end
    check("abort_no_done", dones, 0);
    check("abort_word6_committed", mem[6], 32'h0000_0013);
    check("abort_word7_untouched", mem[7], 32'h0);
    run_op(16'd27, 16'h1357, lat, e, s);
    check("after_abort_word7", mem[7], 32'h5700_0000);
    check("after_abort_latency", lat, 6);
    @(negedge clk);
    rst = 1'b1; start_i = 1'b1; field_addr_i = 16'd24;
    @(posedge clk); #1 rst = 1'b0; start_i = 1'b0;
    check("rst_beats_start", busy_o, 0);
    for (int k = 0; k < 40; k++) begin
      a = 16'($urandom_range(0, 65535));
      if (k < 8) a = {a[15:2], 2'b11};
      v = 16'($urandom);
      a1 = a + 16'd1;
      wa = a[15:2];
      wb = a1[15:2];
      poke(wa, $urandom);
      poke(wb, $urandom);
      ea = put_byte(mem[wa], a[1:0], v[15:8]);
      eb = mem[wb];
      if (wb == wa) ea = put_byte(ea, a1[1:0], v[7:0]);
      else eb = put_byte(eb, a1[1:0], v[7:0]);
      run_op(a, v, lat, e, s);
      check($sformatf("rand%0d_word_a", k), mem[wa], ea);
      if (wb != wa) check($sformatf("rand%0d_word_b", k), mem[wb], eb);
      check($sformatf("rand%0d_latency", k), lat, (wb == wa) ? 4 : 6);
      check($sformatf("rand%0d_err", k), e, 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
